// File: rtl/fpu_mul_exp_seq_if.sv
// fpu_mul_exp_seq_if
// Groups the request handshake, the output handshake and the per-stage
// control outputs of the FPU multiply exponent sequencer.
//   slave  : sequencer side (takes request and out_rdy, drives the rest)
//   master : requester/consumer side
// Signals:
//   req_vld/req_op/req_cls/req_rdy  request handshake (op 1 fmuld, 2 fmuls, 3 fsmuld)
//   out_vld/out_rdy                 m6 result handshake
//   m6stg_step                      global pipe advance
//   m1stg_*, m2stg_*, m5stg_fmuld   stage opcode qualifiers and m2 exponent selects
//   fmul_clken_l                    active-low clock enable
//   busy_cnt                        number of valid stages
interface fpu_mul_exp_seq_if;
    logic       req_vld;
    logic [1:0] req_op;
    logic [2:0] req_cls;
    logic       req_rdy;
    logic       m6stg_step;
    logic       m1stg_dblop;
    logic       m1stg_sngop;
    logic       m1stg_fsmuld;
    logic       m2stg_exp_expadd;
    logic       m2stg_exp_0bff;
    logic       m2stg_exp_017f;
    logic       m2stg_exp_04ff;
    logic       m2stg_exp_zero;
    logic       m2stg_fmuld;
    logic       m2stg_fmuls;
    logic       m2stg_fsmuld;
    logic       m5stg_fmuld;
    logic       fmul_clken_l;
    logic       out_vld;
    logic       out_rdy;
    logic [3:0] busy_cnt;

    modport slave (
        input  req_vld, req_op, req_cls, out_rdy,
        output req_rdy, m6stg_step,
        output m1stg_dblop, m1stg_sngop, m1stg_fsmuld,
        output m2stg_exp_expadd, m2stg_exp_0bff, m2stg_exp_017f, m2stg_exp_04ff, m2stg_exp_zero,
        output m2stg_fmuld, m2stg_fmuls, m2stg_fsmuld, m5stg_fmuld,
        output fmul_clken_l, out_vld, busy_cnt
    );

    modport master (
        output req_vld, req_op, req_cls, out_rdy,
        input  req_rdy, m6stg_step,
        input  m1stg_dblop, m1stg_sngop, m1stg_fsmuld,
        input  m2stg_exp_expadd, m2stg_exp_0bff, m2stg_exp_017f, m2stg_exp_04ff, m2stg_exp_zero,
        input  m2stg_fmuld, m2stg_fmuls, m2stg_fsmuld, m5stg_fmuld,
        input  fmul_clken_l, out_vld, busy_cnt
    );
endinterface

// File: rtl/fpu_mul_exp_seq.sv
// fpu_mul_exp_seq
// Pipeline sequencer for the FPU multiply exponent datapath. Tracks valid,
// opcode and exponent class through stages m1, m2, m3a, m3b, m3, m4, m5, m6
// and derives the global advance, stage qualifiers, one-hot m2 exponent
// selects and the active-low clock enable. A stalled m6 freezes the whole pipe.
// Ports:
//   rclk    global clock
//   arst_l  asynchronous active-low reset
//   pipe    fpu_mul_exp_seq_if.slave (request/output handshakes and controls)
module fpu_mul_exp_seq (
    input  logic rclk,
    input  logic arst_l,
    fpu_mul_exp_seq_if.slave pipe
);

    localparam int NSTG = 8;
    // Stage index: 0 m1, 1 m2, 2 m3a, 3 m3b, 4 m3, 5 m4, 6 m5, 7 m6
    localparam int M1 = 0;
    localparam int M2 = 1;
    localparam int M5 = 6;
    localparam int M6 = 7;

    localparam logic [1:0] OP_FMULD  = 2'd1;
    localparam logic [1:0] OP_FMULS  = 2'd2;
    localparam logic [1:0] OP_FSMULD = 2'd3;

    logic [NSTG-1:0] vld;
    logic [1:0]      op  [NSTG];
    logic [2:0]      cls [NSTG];
    logic [3:0]      busy;

    logic step;
    logic accept;
    logic drain;

    // Only a full m6 that the consumer refuses can hold the pipe.
    assign step   = !(vld[M6] & !pipe.out_rdy);
    assign accept = pipe.req_vld & (pipe.req_op != 2'd0) & step;
    assign drain  = vld[M6] & pipe.out_rdy;

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            vld <= '0;
            for (int k = 0; k < NSTG; k++) begin
                op[k]  <= 2'd0;
                cls[k] <= 3'd0;
            end
        end else if (step) begin
            vld <= {vld[NSTG-2:0], accept};
            op[M1]  <= accept ? pipe.req_op  : 2'd0;
            cls[M1] <= accept ? pipe.req_cls : 3'd0;
            for (int k = 1; k < NSTG; k++) begin
                op[k]  <= op[k-1];
                cls[k] <= cls[k-1];
            end
        end
    end

    // Running population count of vld, kept incrementally.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            busy <= 4'd0;
        end else begin
            case ({accept, drain})
                2'b10:   busy <= busy + 4'd1;
                2'b01:   busy <= busy - 4'd1;
                default: busy <= busy;
            endcase
        end
    end

    always_comb begin
        pipe.m2stg_exp_expadd = 1'b0;
        pipe.m2stg_exp_0bff   = 1'b0;
        pipe.m2stg_exp_017f   = 1'b0;
        pipe.m2stg_exp_04ff   = 1'b0;
        pipe.m2stg_exp_zero   = 1'b0;
        if (vld[M1]) begin
            case (cls[M1])
                3'd0:    pipe.m2stg_exp_expadd = 1'b1;
                3'd1:    pipe.m2stg_exp_0bff   = 1'b1;
                3'd2:    pipe.m2stg_exp_017f   = 1'b1;
                3'd3:    pipe.m2stg_exp_04ff   = 1'b1;
                default: pipe.m2stg_exp_zero   = 1'b1;
            endcase
        end
    end

    assign pipe.m1stg_dblop  = vld[M1] & (op[M1] == OP_FMULD);
    assign pipe.m1stg_sngop  = vld[M1] & ((op[M1] == OP_FMULS) | (op[M1] == OP_FSMULD));
    assign pipe.m1stg_fsmuld = vld[M1] & (op[M1] == OP_FSMULD);

    assign pipe.m2stg_fmuld  = vld[M2] & (op[M2] == OP_FMULD);
    assign pipe.m2stg_fmuls  = vld[M2] & (op[M2] == OP_FMULS);
    assign pipe.m2stg_fsmuld = vld[M2] & (op[M2] == OP_FSMULD);

    assign pipe.m5stg_fmuld  = vld[M5] & (op[M5] == OP_FMULD);

    assign pipe.m6stg_step   = step;
    assign pipe.req_rdy      = step;
    assign pipe.out_vld      = vld[M6];
    assign pipe.busy_cnt     = busy;
    assign pipe.fmul_clken_l = !((busy != 4'd0) | pipe.req_vld);

endmodule

// File: doc/fpu_mul_exp_seq.md
# fpu_mul_exp_seq

Pipeline sequencer for the FPU multiply exponent datapath. It accepts one multiply request per cycle and tracks validity and opcode through the eight exponent stages: m1, m2, m3a, m3b, m3, m4, m5 and m6 (the output register). It generates the global advance (`m6stg_step`), the per-stage opcode qualifiers, the one-hot m2 exponent-mux selects and the active-low clock enable. A registered output handshake stalls the whole pipe as a unit.

## Interface
Parameters: none.

Ports:
- rclk  in  1  global clock; single clock domain
- arst_l  in  1  asynchronous active-low reset
- req_vld  in  1  new multiply request presented
- req_op  in  2  2'd1 fmuld, 2'd2 fmuls, 2'd3 fsmuld, 2'd0 illegal (ignored, not accepted)
- req_cls  in  3  exponent class: 0 normal, 1 const 0bff, 2 const 017f, 3 const 04ff, 4 zero, 5-7 treated as zero
- req_rdy  out  1  equals m6stg_step; request accepted when req_vld & req_op!=0 & req_rdy
- m6stg_step  out  1  advance all pipe registers
- m1stg_dblop / m1stg_sngop / m1stg_fsmuld  out  1 each  m1 opcode qualifiers, gated by m1 valid
- m2stg_exp_expadd / _0bff / _017f / _04ff / _zero  out  1 each  one-hot m2 mux selects from m1 class, gated by m1 valid
- m2stg_fmuld / m2stg_fmuls / m2stg_fsmuld  out  1 each  m2 opcode, gated by m2 valid
- m5stg_fmuld  out  1  m5 is fmuld and valid
- fmul_clken_l  out  1  low when any stage valid or a request is pending
- out_vld  out  1  m6 holds a valid result
- out_rdy  in  1  consumer takes m6 this cycle
- busy_cnt  out  4  number of valid stages, 0-8

## Operation
- Eight stage registers, each holding {vld, op[1:0], cls[2:0]}.
  - On m6stg_step, stage k loads stage k-1.
  - m1 loads the request if it is accepted; otherwise m1 loads a bubble (vld=0).
- m6stg_step = !(out_vld & !out_rdy).
  - The pipe advances whenever m6 is empty or being drained, including while it holds only bubbles.
  - A full pipe with an accepting consumer sustains one result per cycle.
- m1stg_dblop is high for fmuld. m1stg_sngop is high for fmuls and fsmuld. m1stg_fsmuld is high for fsmuld only. All three are 0 when m1 is invalid.
- m2 selects are one-hot while m1 is valid and all-zero when m1 is invalid:
  - cls 0 → expadd
  - cls 1 → 0bff
  - cls 2 → 017f
  - cls 3 → 04ff
  - cls 4-7 → zero
- Illegal op (req_op = 0): not accepted and m1 loads a bubble. The requester is responsible for dropping it.
- busy_cnt is the population count of the eight vld bits, held in a register and updated each cycle:
  - +1 on accept;
  - -1 when m6 is drained (out_vld & out_rdy);
  - both or neither → unchanged.
- fmul_clken_l = !(busy_cnt != 0 | req_vld).

## Timing
- Reset (arst_l low, asynchronous): all vld bits, ops and classes are 0.
  - busy_cnt = 0, out_vld = 0, fmul_clken_l = 1.
  - m6stg_step = 1 and req_rdy = 1.
  - All qualifiers and selects are 0.
- Reset asserted mid-operation discards all in-flight ops. No output pulses on release.
- Latency: a request accepted at edge N has out_vld high after edge N+7. It has been in m1 during cycle N+1 (the cycle after edge N), so m1 qualifiers and m2 selects are valid in that cycle.
- Stall: when out_vld=1 and out_rdy=0, m6stg_step=0 and req_rdy=0. All stage contents hold and all qualifier outputs hold steady.
- Accept and drain in the same cycle: both happen and busy_cnt is unchanged.
- m5stg_fmuld and m2 qualifiers follow their stage content and change only on step edges.

## Test plan
- Reset, then a single fmuld with cls 0 at cycle 1:
  - m1stg_dblop=1 and m2stg_exp_expadd=1 in cycle 2;
  - m2stg_fmuld=1 in cycle 3;
  - out_vld=1 in cycle 9 with out_rdy=1; busy_cnt returns to 0 in cycle 10.
- Back-to-back fmuls, fsmuld, fmuld with cls 1, 2, 4 and out_rdy=1:
  - m2 selects go 0bff, 017f, zero on consecutive cycles;
  - m1stg_fsmuld=1 only for the second op;
  - out_vld high for 3 consecutive cycles.
- Fill the pipe (8 requests) with out_rdy=0:
  - busy_cnt=8; step=0; req_rdy=0; contents hold for 5 cycles;
  - raise out_rdy → one result per cycle, no loss or duplication.
- req_op=0 with req_vld=1 → busy_cnt unchanged, out_vld never asserts, fmul_clken_l=0 while req_vld=1.
- Assert arst_l low with 4 ops in flight → out_vld=0, busy_cnt=0 and fmul_clken_l=1 immediately (asynchronously); no output after release.
- Idle with req_vld=0 and the pipe empty → fmul_clken_l=1 and all select/qualifier outputs are 0.
